// File: rtl/shredder_feeder.sv
// Frame-buffered row feeder for a column array of shredder Life cells.
// Define SHREDDER_FEEDER_WRAP_EN for a toroidal board (borders taken from the opposite edge row).
module shredder_feeder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            row_in,
    input  logic                        row_valid,
    output logic                        row_ready,
    output logic [WIDTH-1:0]            col_din,
    output logic                        col_rst,
    output logic                        res_valid,
    output logic [$clog2(HEIGHT)-1:0]   res_row,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int unsigned RW = $clog2(HEIGHT);
    localparam int unsigned CW = $clog2(HEIGHT + 3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CLEAR  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     lc;
    logic [CW-1:0]     sc;
    logic [WIDTH-1:0]  buffer [HEIGHT];
    logic [WIDTH-1:0]  top_border;
    logic [WIDTH-1:0]  bottom_border;
    logic [WIDTH-1:0]  col_din_q;
    logic              res_valid_q;
    logic [RW-1:0]     res_row_q;
    logic              frame_done_q;
    logic              accept;
    logic [RW-1:0]     wr_idx;

`ifdef SHREDDER_FEEDER_WRAP_EN
    assign top_border    = buffer[HEIGHT-1];
    assign bottom_border = buffer[0];
`else
    assign top_border    = '0;
    assign bottom_border = '0;
`endif

    assign row_ready = !rst && (state == IDLE || state == LOAD);
    assign busy      = !rst && (state != IDLE);
    assign col_rst   = rst || (state == CLEAR);
    assign accept    = row_valid && row_ready;
    assign wr_idx    = (state == IDLE) ? '0 : RW'(lc);

    // Outputs forced to their idle values while reset is held.
    assign col_din    = rst ? '0 : col_din_q;
    assign res_valid  = !rst && res_valid_q;
    assign res_row    = rst ? '0 : res_row_q;
    assign frame_done = !rst && frame_done_q;

    // Frame buffer: written only on handshake, never cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[wr_idx] <= row_in;
        end
    end

    // Sequencer: load rows, clear array, stream bordered rows, drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lc           <= '0;
            sc           <= '0;
            col_din_q    <= '0;
            res_valid_q  <= 1'b0;
            res_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_din_q    <= '0;
            res_valid_q  <= 1'b0;
            res_row_q    <= '0;
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lc    <= CW'(1);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        lc <= lc + CW'(1);
                        if (lc == CW'(HEIGHT - 1)) begin
                            state <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    sc        <= '0;
                    col_din_q <= top_border;
                    state     <= STREAM;
                end
                STREAM: begin
                    sc <= sc + CW'(1);
                    // Registers hold the value for the following cycle's sc.
                    if (sc < CW'(HEIGHT)) begin
                        col_din_q <= buffer[RW'(sc)];
                    end else if (sc == CW'(HEIGHT)) begin
                        col_din_q <= bottom_border;
                    end
                    if (sc >= CW'(2)) begin
                        res_valid_q <= 1'b1;
                        res_row_q   <= RW'(sc - CW'(2));
                    end
                    if (sc == CW'(HEIGHT + 1)) begin
                        frame_done_q <= 1'b1;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
